// File: rtl/data_ram_arbiter_pkg.sv
// Shared constants and types for the data RAM arbiter: default data-segment base
// address, requester identifiers and the read-return tag layout.
package data_ram_arbiter_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic bad;
  } rd_tag_t;

endpackage

// File: rtl/ram_addr_map.sv
// Translates a MARS-style byte address into a RAM word index and flags
// accesses that are below the base, beyond the RAM, or not word aligned.
module ram_addr_map
  import data_ram_arbiter_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT
) (
  input  logic [31:0]           addr,
  output logic [ADDR_WIDTH-1:0] word,
  output logic                  valid
);

  localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;

  logic [31:0] offset;

  assign offset = addr - BASE_ADDR;
  assign word   = offset[ADDR_WIDTH+1:2];
  // The explicit lower-bound test keeps underflowed offsets from aliasing into the RAM.
  assign valid  = (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN) && (addr[1:0] == 2'b00);

endmodule

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the MEM stage
// and the loader, with address checking and one-cycle read return.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [31:0]           ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  cpu_gnt,
  output logic                  ldr_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic                  ldr_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  fault,
  output logic                  fault_src
);

  logic                  last_gnt_reg;
  rd_tag_t               tag_reg;
  logic                  fault_reg;
  logic                  fault_src_reg;
  logic [DATA_WIDTH-1:0] cpu_rdata_reg;
  logic [DATA_WIDTH-1:0] ldr_rdata_reg;

  logic                  winner;
  logic                  granted;
  logic [31:0]           sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_WIDTH-1:0] map_word;
  logic                  map_valid;
  logic                  drive;
  logic [DATA_WIDTH-1:0] ret_data;

  // On a conflict the side not granted last wins, bounding the wait to one cycle.
  always_comb begin
    winner = REQ_CPU;
    if (cpu_req && ldr_req) begin
      winner = (last_gnt_reg == REQ_LDR) ? REQ_CPU : REQ_LDR;
    end else if (ldr_req) begin
      winner = REQ_LDR;
    end
  end

  assign granted   = cpu_req | ldr_req;
  assign sel_addr  = (winner == REQ_LDR) ? ldr_addr  : cpu_addr;
  assign sel_we    = (winner == REQ_LDR) ? ldr_we    : cpu_we;
  assign sel_wdata = (winner == REQ_LDR) ? ldr_wdata : cpu_wdata;

  ram_addr_map #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_map (
    .addr  (sel_addr),
    .word  (map_word),
    .valid (map_valid)
  );

  assign cpu_gnt   = cpu_req & (winner == REQ_CPU);
  assign ldr_gnt   = ldr_req & (winner == REQ_LDR);
  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Faulting accesses are still granted but never reach the RAM.
  assign drive     = granted & map_valid;
  assign ram_we    = drive & sel_we;
  assign ram_addr  = drive ? map_word  : '0;
  assign ram_wdata = drive ? sel_wdata : '0;

  assign ret_data   = tag_reg.bad ? '0 : ram_rdata;
  assign cpu_rvalid = tag_reg.valid & (tag_reg.owner == REQ_CPU);
  assign ldr_rvalid = tag_reg.valid & (tag_reg.owner == REQ_LDR);
  assign cpu_rdata  = cpu_rvalid ? ret_data : cpu_rdata_reg;
  assign ldr_rdata  = ldr_rvalid ? ret_data : ldr_rdata_reg;
  assign fault      = fault_reg;
  assign fault_src  = fault_src_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt_reg  <= REQ_LDR;
      tag_reg       <= '0;
      fault_reg     <= 1'b0;
      fault_src_reg <= REQ_CPU;
      cpu_rdata_reg <= '0;
      ldr_rdata_reg <= '0;
    end else begin
      if (granted) begin
        last_gnt_reg <= winner;
      end
      tag_reg.valid <= granted & ~sel_we;
      tag_reg.owner <= winner;
      tag_reg.bad   <= ~map_valid;
      fault_reg     <= granted & ~map_valid;
      if (granted && !map_valid) begin
        fault_src_reg <= winner;
      end
      if (cpu_rvalid) begin
        cpu_rdata_reg <= ret_data;
      end
      if (ldr_rvalid) begin
        ldr_rdata_reg <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed and randomized checks of data_ram_arbiter against a behavioural
// model of the address map, round-robin rule and one-cycle read return.
module tb_data_ram_arbiter;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic        cpu_gnt, ldr_gnt, cpu_stall, cpu_rvalid, ldr_rvalid;
  logic [31:0] cpu_rdata, ldr_rdata;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        fault, fault_src;

  int tests = 0;
  int fails = 0;

  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];

  bit          ref_last_ldr;
  bit          pend_valid, pend_cpu, pend_fault, pend_fsrc;
  logic [31:0] pend_data;
  logic [31:0] exp_cpu_rdata, exp_ldr_rdata;

  data_ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .cpu_gnt    (cpu_gnt),
    .ldr_gnt    (ldr_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .ldr_rvalid (ldr_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_rdata  (ldr_rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .fault      (fault),
    .fault_src  (fault_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM macro stand-in.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && ((la - lb) < 1024) && ((la % 4) == 0);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic ref_reset();
    ref_last_ldr  = 1'b1;
    pend_valid    = 1'b0;
    pend_cpu      = 1'b0;
    pend_fault    = 1'b0;
    pend_fsrc     = 1'b0;
    pend_data     = '0;
    exp_cpu_rdata = '0;
    exp_ldr_rdata = '0;
  endtask

  task automatic do_cycle(input bit creq, input bit cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                          input bit lreq, input bit lwe, input logic [31:0] laddr, input logic [31:0] lwd);
    bit          cpu_wins, ldr_wins, any, ok, we, exp_we;
    logic [31:0] a, wd;
    @(posedge clk);
    #1;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    ldr_req = lreq; ldr_we = lwe; ldr_addr = laddr; ldr_wdata = lwd;
    #2;
    chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, pend_valid && pend_cpu});
    chk("ldr_rvalid", {31'b0, ldr_rvalid}, {31'b0, pend_valid && !pend_cpu});
    if (pend_valid) begin
      if (pend_cpu) exp_cpu_rdata = pend_data;
      else          exp_ldr_rdata = pend_data;
    end
    chk("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    chk("ldr_rdata", ldr_rdata, exp_ldr_rdata);
    chk("fault", {31'b0, fault}, {31'b0, pend_fault});
    if (pend_fault) chk("fault_src", {31'b0, fault_src}, {31'b0, pend_fsrc});

    cpu_wins = creq && (!lreq || ref_last_ldr);
    ldr_wins = lreq && !cpu_wins;
    any      = cpu_wins || ldr_wins;
    a        = cpu_wins ? caddr : laddr;
    we       = cpu_wins ? cwe : lwe;
    wd       = cpu_wins ? cwd : lwd;
    ok       = addr_ok(a);
    exp_we   = any && ok && we;
    chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, cpu_wins});
    chk("ldr_gnt", {31'b0, ldr_gnt}, {31'b0, ldr_wins});
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, creq && !cpu_wins});
    chk("ram_we", {31'b0, ram_we}, {31'b0, exp_we});
    if (any && ok) chk("ram_addr", {24'b0, ram_addr}, 32'(word_of(a)));
    if (exp_we) chk("ram_wdata", ram_wdata, wd);
    if (!any) begin
      chk("idle_ram_addr", {24'b0, ram_addr}, 32'd0);
      chk("idle_ram_wdata", ram_wdata, 32'd0);
    end
    $display("[TB] t=%0t cpu(req=%0b we=%0b a=%h) ldr(req=%0b we=%0b a=%h) gnt=%0b%0b ram_we=%0b addr=%0d",
             $time, creq, cwe, caddr, lreq, lwe, laddr, cpu_gnt, ldr_gnt, ram_we, ram_addr);

    pend_valid = any && !we;
    pend_cpu   = cpu_wins;
    pend_data  = ok ? ref_mem[word_of(a)] : 32'd0;
    pend_fault = any && !ok;
    pend_fsrc  = ldr_wins;
    if (exp_we) ref_mem[word_of(a)] = wd;
    if (any) ref_last_ldr = ldr_wins;
  endtask

  task automatic idle();
    do_cycle(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 32'h1001_0400 + 4 * $urandom_range(0, 15);
      1:       return BASE - 4 * $urandom_range(1, 16);
      2:       return BASE + 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
      default: return BASE + 4 * $urandom_range(0, 255);
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    ram_mem[1] = 32'hDEAD_BEEF;
    ref_mem[1] = 32'hDEAD_BEEF;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    ref_reset();
    repeat (2) @(posedge clk);
    #3;
    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rst_ldr_rvalid", {31'b0, ldr_rvalid}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_ldr_rdata", ldr_rdata, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fault_src", {31'b0, fault_src}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Continuous conflict from reset alternates CPU, LDR, CPU, LDR.
    repeat (4) do_cycle(1, 0, BASE + 32'd8, 32'd0, 1, 0, BASE + 32'd12, 32'd0);

    // CPU read of word 1.
    do_cycle(1, 0, 32'h1001_0004, 32'd0, 0, 0, 32'd0, 32'd0);
    idle();
    chk("tp_read_deadbeef", cpu_rdata, 32'hDEAD_BEEF);

    // Loader write to the last word, then CPU reads it back.
    do_cycle(0, 0, 32'd0, 32'd0, 1, 1, 32'h1001_03FC, 32'h1234_5678);
    do_cycle(1, 0, 32'h1001_03FC, 32'd0, 0, 0, 32'd0, 32'd0);
    idle();
    chk("tp_write_readback", cpu_rdata, 32'h1234_5678);

    // Out of range, below base (wrap), misaligned.
    do_cycle(1, 0, 32'h1001_0400, 32'd0, 0, 0, 32'd0, 32'd0);
    do_cycle(1, 0, 32'h1000_FFFC, 32'd0, 0, 0, 32'd0, 32'd0);
    do_cycle(1, 1, 32'h1001_0002, 32'hFFFF_FFFF, 0, 0, 32'd0, 32'd0);
    idle();

    // Reset asserted the cycle after a granted read.
    do_cycle(1, 0, 32'h1001_0004, 32'd0, 0, 0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cpu_req = 0; ldr_req = 0; cpu_we = 0; ldr_we = 0;
    #2;
    ref_reset();
    chk("midrst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("midrst_fault", {31'b0, fault}, 32'd0);
    chk("midrst_cpu_rdata", cpu_rdata, 32'd0);
    chk("midrst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("midrst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    do_cycle(1, 0, BASE, 32'd0, 1, 0, BASE + 32'd4, 32'd0);
    chk("post_rst_cpu_first", {31'b0, cpu_gnt}, 32'd1);
    do_cycle(1, 0, BASE, 32'd0, 1, 0, BASE + 32'd4, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      do_cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0), rand_addr(), $urandom,
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0), rand_addr(), $urandom);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Shares the single-port synchronous data RAM between two requesters: the pipeline MEM stage (CPU) and the program/data loader (LDR). Translates MARS-style byte addresses (data segment at 0x10010000) to RAM word indices, range- and alignment-checks them, arbitrates round-robin per cycle, and returns read data with a one-cycle latency. Sits between the MEM stage / loader and the RAM macro; drives the pipeline stall for the MEM stage.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 8, RAM word-index width (256 words)
- BASE_ADDR, 32'h10010000, byte address mapped to RAM word 0

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req / ldr_req  in  1  access request, held until granted
- cpu_we / ldr_we  in  1  1 = write, 0 = read
- cpu_addr / ldr_addr  in  32  byte address
- cpu_wdata / ldr_wdata  in  DATA_WIDTH  write data
- cpu_gnt / ldr_gnt  out  1  request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid / ldr_rvalid  out  1  read data valid (one-cycle pulse)
- cpu_rdata / ldr_rdata  out  DATA_WIDTH  read data, held between pulses
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM word index
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid cycle after address
- fault  out  1  registered pulse: granted access was out of range or misaligned
- fault_src  out  1  requester of faulting access (0 CPU, 1 LDR)

## Operation
- Mapping: offset = addr - BASE_ADDR (32-bit); word = offset >> 2. Valid iff addr >= BASE_ADDR, offset < 4·2^ADDR_WIDTH, addr[1:0] == 0.
- Arbitration per cycle, combinational: single requester wins; both requesting → winner is the one not granted last (last_gnt register). Only granting updates last_gnt.
- Reset: last_gnt = LDR (CPU wins first conflict); all rvalid, rdata, fault, fault_src = 0.
- Granted valid access: ram_addr = word[ADDR_WIDTH-1:0], ram_we = winner's we, ram_wdata = winner's wdata.
- Granted invalid access: gnt still asserted, ram_we forced 0, fault pulses next cycle with fault_src; a read returns rvalid with rdata = 0.
- No grant: ram_we = 0, ram_addr/ram_wdata = 0.
- Read return: registered owner tag + valid bit; next cycle the tagged requester's rvalid pulses and its rdata register loads ram_rdata (or 0 on fault). Other requester's rdata unchanged.
- Writes produce no rvalid.

## Timing
- Grant, stall, RAM drive: same cycle as request (combinational).
- Read latency: rvalid exactly 1 cycle after gnt; back-to-back granted reads give rvalid every cycle.
- Starvation bound: continuously requesting side waits at most 1 cycle.
- Write then read same word in consecutive cycles: read returns new value (RAM write-first not required; write commits before next-cycle read).
- Reset asserted mid-operation: pending rvalid/fault dropped immediately; no output pulses after release until new grant.
- Address wrap: addr < BASE_ADDR (subtraction underflows) is a fault, never aliasing.

## Structure
- Shared package: BASE_ADDR default, requester ID constants REQ_CPU = 0, REQ_LDR = 1.
- One sub-module: ram_addr_map (combinational offset/word/valid computation), instantiated once on the muxed winner address.

## Test plan
- CPU read 0x10010004, RAM word 1 = 0xDEADBEEF → cpu_gnt same cycle, ram_addr = 1, cpu_rvalid next cycle, cpu_rdata = 0xDEADBEEF.
- Both request continuously from reset → grants CPU, LDR, CPU, LDR; cpu_stall high on LDR cycles only.
- LDR write 0x100103FC data 0x12345678 → ram_we = 1, ram_addr = 255; following CPU read of same address returns 0x12345678.
- CPU read 0x10010400 and 0x1000FFFC and 0x10010002 → gnt, ram_we = 0, fault = 1, fault_src = 0, cpu_rvalid with rdata 0.
- Reset asserted the cycle after a granted read → no rvalid, all outputs 0; after release first conflict grants CPU.
